sigmoid_bwd: RTL and testbench

- Backward-pass companion to the forward `sigmoid` activation. It computes the gradient through the activation: grad_out = grad_in * y * (1 - y), where y is the forward sigmoid output.
- All data is signed Q16.16.
- It uses two multi-cycle shift-add multiplies behind a valid/ready handshake, one operation in flight at a time.
- It sits between the loss/upstream gradient path and the preceding layer's weight-update logic.

---
 rtl/sigmoid_bwd.sv | 158 +++++++++++++++
 tb/tb_sigmoid_bwd.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_bwd.sv
// rtl/sigmoid_bwd.sv - sigmoid backward pass: grad_out = grad_in * y * (1 - y), Q16.16
// Two serial shift-add multiplies; one operand pair in flight at a time.
module sigmoid_bwd #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] grad_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] grad_out,
    output logic [DATA_W-1:0] dsig_out,
    output logic              clamp_flag
);
    localparam int CW  = $clog2(FRAC_W + 1);
    localparam int DIW = $clog2(FRAC_W);
    localparam int YW  = FRAC_W + 1;
    localparam int P1W = 2 * YW;
    localparam int P2W = 2 * DATA_W;

    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1) << FRAC_W;
    localparam logic [YW-1:0]     ONE_Y  = YW'(1) << FRAC_W;
    localparam logic [CW-1:0]     CNT_M1 = CW'(FRAC_W);
    localparam logic [CW-1:0]     CNT_M2 = CW'(FRAC_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLAMP,
        S_MUL1,
        S_MUL2,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] y_raw;
    logic [DATA_W-1:0] grad_r;
    logic [YW-1:0]     y_c;
    logic [YW-1:0]     om;
    logic              clamp_r;
    logic [P1W-1:0]    acc1;
    logic [FRAC_W-1:0] d_r;
    logic [P2W-1:0]    acc2;

    logic [DATA_W-1:0] y_clamped;
    logic              clamp_hit;
    logic [P1W-1:0]    mul1_sum;
    logic [P2W-1:0]    grad_ext;
    logic [P2W-1:0]    mul2_sum;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)         state_nx = S_CLAMP;
            S_CLAMP:                       state_nx = S_MUL1;
            S_MUL1:  if (cnt == CNT_M1)    state_nx = S_MUL2;
            S_MUL2:  if (cnt == CNT_M2)    state_nx = S_ROUND;
            S_ROUND:                       state_nx = S_DONE;
            S_DONE:  if (out_ready)        state_nx = S_IDLE;
            default:                       state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (en) begin
            state <= state_nx;
        end
    end

    // The counter restarts on every state change so each multiply phase counts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        y_clamped = y_raw;
        clamp_hit = 1'b0;
        if (y_raw[DATA_W-1]) begin
            y_clamped = '0;
            clamp_hit = 1'b1;
        end else if (y_raw > ONE) begin
            y_clamped = ONE;
            clamp_hit = 1'b1;
        end
    end

    assign grad_ext = {{DATA_W{grad_r[DATA_W-1]}}, grad_r};
    assign mul1_sum = acc1 + (om[cnt] ? ({{YW{1'b0}}, y_c} << cnt) : '0);
    assign mul2_sum = acc2 + (d_r[cnt[DIW-1:0]] ? (grad_ext << cnt) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_raw      <= '0;
            grad_r     <= '0;
            y_c        <= '0;
            om         <= '0;
            clamp_r    <= 1'b0;
            acc1       <= '0;
            d_r        <= '0;
            acc2       <= '0;
            grad_out   <= '0;
            dsig_out   <= '0;
            clamp_flag <= 1'b0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        y_raw  <= y_in;
                        grad_r <= grad_in;
                    end
                end
                S_CLAMP: begin
                    y_c     <= y_clamped[YW-1:0];
                    om      <= ONE_Y - y_clamped[YW-1:0];
                    clamp_r <= clamp_hit;
                    acc1    <= '0;
                end
                S_MUL1: begin
                    acc1 <= mul1_sum;
                    if (cnt == CNT_M1) begin
                        d_r  <= mul1_sum[2*FRAC_W-1:FRAC_W];
                        acc2 <= '0;
                    end
                end
                S_MUL2: begin
                    acc2 <= mul2_sum;
                end
                S_ROUND: begin
                    // Taking the upper slice of the two's complement product floors toward -inf.
                    grad_out   <= acc2[FRAC_W+DATA_W-1:FRAC_W];
                    dsig_out   <= DATA_W'(d_r);
                    clamp_flag <= clamp_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sigmoid_bwd.sv
// tb/tb_sigmoid_bwd.sv - scoreboard bench for sigmoid_bwd against an arithmetic reference model
module tb_sigmoid_bwd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] y_in = '0;
    logic [31:0] grad_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] grad_out;
    logic [31:0] dsig_out;
    logic        clamp_flag;

    typedef struct {
        logic [31:0] g;
        logic [31:0] d;
        logic        c;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    sigmoid_bwd #(.DATA_W(32), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .y_in(y_in), .grad_in(grad_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .grad_out(grad_out), .dsig_out(dsig_out), .clamp_flag(clamp_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] y, input logic [31:0] g);
        exp_t e;
        longint yc;
        longint p;
        e.c = y[31] || (y > 32'h0001_0000);
        if (y[31])                    yc = 0;
        else if (y > 32'h0001_0000)   yc = 65536;
        else                          yc = longint'(y);
        e.d = 32'((yc * (65536 - yc)) / 65536);
        p = longint'($signed(g)) * longint'(e.d);
        e.g = 32'(p >>> 16);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && en && out_valid && out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_result", {31'b0, out_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("grad_out", grad_out, e.g);
                check("dsig_out", dsig_out, e.d);
                check("clamp_flag", {31'b0, clamp_flag}, {31'b0, e.c});
            end
        end
    end

    task automatic run_op(input logic [31:0] y, input logic [31:0] g, input bit stall, input int hold);
        exp_t e;
        int n;
        e = model(y, g);
        y_in = y;
        grad_in = g;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check("in_ready_idle", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        check("in_ready_after_accept", {31'b0, in_ready}, 32'h0);
        // Busy-state junk on the inputs must be ignored.
        y_in = $urandom;
        grad_in = $urandom;
        n = 0;
        while (!out_valid && n <= 200) begin
            @(posedge clk);
            #1;
            n++;
            if (stall && n == 20) begin
                en = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                en = 1'b1;
            end
        end
        check("latency", 32'(n), stall ? 32'd40 : 32'd35);
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_grad", grad_out, e.g);
            check("hold_dsig", dsig_out, e.d);
            check("hold_in_ready", {31'b0, in_ready}, 32'h0);
            check("hold_out_valid", {31'b0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_handshake", {31'b0, in_ready}, 32'h1);
        check("out_valid_after_handshake", {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        int seen;
        logic [31:0] ry;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_grad_out", grad_out, 32'h0);
        check("rst_dsig_out", dsig_out, 32'h0);
        check("rst_clamp_flag", {31'b0, clamp_flag}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'h0000_8000, 32'h0001_0000, 1'b0, 0);
        run_op(32'h0000_C000, 32'hFFFE_0000, 1'b0, 0);
        run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 0);
        run_op(32'h0001_0000, 32'h8765_4321, 1'b0, 1);
        run_op(32'hFFFF_0000, 32'h0003_0000, 1'b0, 0);
        run_op(32'h0002_0000, 32'hFFF0_0000, 1'b0, 0);
        run_op(32'h0000_0001, 32'h0001_0000, 1'b0, 0);
        run_op(32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'h0000_4000, 32'h0005_8000, 1'b0, 10);
        run_op(32'h0000_A000, 32'hFFFD_4000, 1'b1, 2);

        // Abort mid-MUL1: asynchronous reset, then no stray result.
        y_in = 32'h0000_6000;
        grad_in = 32'h0002_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'h1);
        check("abort_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        out_ready = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("abort_no_result", 32'(seen), 32'h0);

        for (int k = 0; k < 20; k++) begin
            ry = (k % 3 == 0) ? $urandom : 32'($urandom_range(0, 65536));
            run_op(ry, $urandom, (k % 7 == 3), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
